// File: rtl/conv2_win_gen.sv
// conv2_win_gen: 5x5 sliding-window generator for a three-channel raster pixel stream
// Optional feature macro: CONV2_WIN_FRAME_DONE_EN (adds the frame_done output)
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   valid_in                    one pixel per channel presented this cycle
//   data_in1..3                 channel pixels, raster order, channels in lockstep
//   win1..3                     registered 5x5 windows, element 5*r+c at [k*DATA_BITS +: DATA_BITS]
//   valid_out_buf               one-cycle pulse when win1..3 carry a fresh window
//   frame_done                  (optional) pulse with the last window of a frame
module conv2_win_gen #(
    parameter int WIDTH     = 12,
    parameter int HEIGHT    = 12,
    parameter int DATA_BITS = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic [DATA_BITS-1:0]      data_in1,
    input  logic [DATA_BITS-1:0]      data_in2,
    input  logic [DATA_BITS-1:0]      data_in3,
    output logic [25*DATA_BITS-1:0]   win1,
    output logic [25*DATA_BITS-1:0]   win2,
    output logic [25*DATA_BITS-1:0]   win3,
    output logic                      valid_out_buf
`ifdef CONV2_WIN_FRAME_DONE_EN
    ,
    output logic                      frame_done
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    // The incoming pixel acts as tap 0, so 4*WIDTH+4 stored entries give 4*WIDTH+5 taps.
    localparam int DEPTH = 4*WIDTH + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH-1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT-1);

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [DATA_BITS-1:0]   din [3];
    logic [DATA_BITS-1:0]   lb_q [3][DEPTH];
    logic [24:0][DATA_BITS-1:0] win_d [3];
    logic [25*DATA_BITS-1:0] win_q [3];
    logic                   vout_q, fire, col_end;

    assign din[0] = data_in1;
    assign din[1] = data_in2;
    assign din[2] = data_in3;
    assign win1 = win_q[0];
    assign win2 = win_q[1];
    assign win3 = win_q[2];
    assign valid_out_buf = vout_q;

    always_comb begin
        col_end = col_q == COL_LAST;
        col_d   = col_end ? '0 : col_q + CW'(1);
        row_d   = !col_end ? row_q : (row_q == ROW_LAST ? '0 : row_q + RW'(1));
        fire    = valid_in && row_q >= RW'(4) && col_q >= CW'(4);
    end

    // Window element (r,c) lies (4-r)*WIDTH + (4-c) pixels behind the one being accepted.
    for (genvar g = 0; g < 3; g++) begin : g_ch
        for (genvar k = 0; k < 25; k++) begin : g_tap
            localparam int OFF = (4 - k/5)*WIDTH + (4 - k%5);
            if (OFF == 0) begin : g_new
                assign win_d[g][k] = din[g];
            end else begin : g_old
                assign win_d[g][k] = lb_q[g][OFF-1];
            end
        end
    end

    // Line buffers carry no reset; the counters alone decide when their contents are valid.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int g = 0; g < 3; g++) begin
                lb_q[g][0] <= din[g];
                for (int i = 1; i < DEPTH; i++) lb_q[g][i] <= lb_q[g][i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            vout_q <= 1'b0;
            win_q  <= '{default: '0};
        end else begin
            vout_q <= fire;
            if (valid_in) begin
                col_q <= col_d;
                row_q <= row_d;
            end
            if (fire) begin
                for (int g = 0; g < 3; g++) win_q[g] <= win_d[g];
            end
        end
    end

`ifdef CONV2_WIN_FRAME_DONE_EN
    logic fd_q;
    assign frame_done = fd_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fd_q <= 1'b0;
        else        fd_q <= fire && col_end && row_q == ROW_LAST;
    end
`endif
endmodule

// File: tb/tb_conv2_win_gen.sv
// tb_conv2_win_gen: self-checking bench for conv2_win_gen against a frame-array window model
module tb_conv2_win_gen;
    localparam int W  = 12;
    localparam int H  = 12;
    localparam int DB = 12;
    localparam int N  = W*H;
    localparam int WB = 25*DB;

    logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0;
    logic [DB-1:0] d1 = '0, d2 = '0, d3 = '0;
    logic [WB-1:0] win1, win2, win3;
    logic vob;
`ifdef CONV2_WIN_FRAME_DONE_EN
    logic fd;
`endif

    conv2_win_gen #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .data_in1(d1), .data_in2(d2), .data_in3(d3),
        .win1(win1), .win2(win2), .win3(win3),
        .valid_out_buf(vob)
`ifdef CONV2_WIN_FRAME_DONE_EN
        , .frame_done(fd)
`endif
    );

    always #5 clk = ~clk;

    logic [DB-1:0] fr [3][N];
    logic [WB-1:0] ew [3];
    logic [WB-1:0] first_w1, first_w2, last_w1;
    int pos, errors, checks, nwin, nfd, first_pix;
    bit seen;

    function automatic logic [DB-1:0] el(input logic [WB-1:0] w, input int k);
        return w[k*DB +: DB];
    endfunction

    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_idx();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < N; i++) fr[c][i] = DB'(i + 1000*c);
    endtask

    task automatic load_rand();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < N; i++) fr[c][i] = DB'($urandom);
    endtask

    // Drive one cycle and check the registered outputs 1 time unit after the edge.
    task automatic step(input bit v);
        bit ev, efd;
        int r, c, cp;
        valid_in = v;
        d1 = v ? fr[0][pos] : DB'($urandom);
        d2 = v ? fr[1][pos] : DB'($urandom);
        d3 = v ? fr[2][pos] : DB'($urandom);
        r = pos / W;
        c = pos % W;
        ev = v && r >= 4 && c >= 4;
        efd = ev && pos == N-1;
        if (ev)
            for (int ch = 0; ch < 3; ch++)
                for (int k = 0; k < 25; k++)
                    ew[ch][k*DB +: DB] = fr[ch][(r - 4 + k/5)*W + c - 4 + k%5];
        cp = pos;
        if (v) pos = (pos + 1) % N;
        @(posedge clk);
        #1;
        chk("valid", WB'(vob), WB'(ev));
        chk("win1", win1, ew[0]);
        chk("win2", win2, ew[1]);
        chk("win3", win3, ew[2]);
`ifdef CONV2_WIN_FRAME_DONE_EN
        chk("frame_done", WB'(fd), WB'(efd));
        if (fd) nfd++;
`else
        if (efd) nfd++;
`endif
        if (vob) begin
            nwin++;
            if (!seen) begin
                seen = 1;
                first_pix = cp;
                first_w1 = win1;
                first_w2 = win2;
            end
            last_w1 = win1;
        end
    endtask

    task automatic run_frame(input bit stall);
        int acc = 0;
        for (int t = 0; t < 20*N && acc < N; t++) begin
            bit v = stall ? bit'($urandom % 2) : 1'b1;
            step(v);
            if (v) acc++;
        end
        chk("frame_timeout", WB'(acc), WB'(N));
    endtask

    task automatic check_idx_frame(input string tag);
        chk({tag, "_first_pix"}, WB'(first_pix), WB'(52));
        chk({tag, "_w1_e0"}, WB'(el(first_w1, 0)), WB'(0));
        chk({tag, "_w1_e24"}, WB'(el(first_w1, 24)), WB'(52));
        chk({tag, "_w1_e12"}, WB'(el(first_w1, 12)), WB'(26));
        chk({tag, "_w2_e0"}, WB'(el(first_w2, 0)), WB'(1000));
        chk({tag, "_nwin"}, WB'(nwin), WB'(64));
        chk({tag, "_last_e24"}, WB'(el(last_w1, 24)), WB'(143));
        chk({tag, "_last_e0"}, WB'(el(last_w1, 0)), WB'(91));
        chk({tag, "_nfd"}, WB'(nfd), WB'(1));
    endtask

    task automatic clear_stats();
        seen = 0;
        nwin = 0;
        nfd = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        pos = 0;
        for (int c = 0; c < 3; c++) ew[c] = '0;
        load_idx();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", WB'(vob), '0);
        chk("rst_win1", win1, '0);
        chk("rst_win2", win2, '0);
        chk("rst_win3", win3, '0);
        rst_n = 1'b1;

        clear_stats();
        run_frame(1'b0);
        step(1'b0);
        check_idx_frame("full");

        clear_stats();
        run_frame(1'b1);
        step(1'b0);
        check_idx_frame("stall");

        clear_stats();
        run_frame(1'b0);
        seen = 0;
        run_frame(1'b0);
        step(1'b0);
        chk("b2b_nwin", WB'(nwin), WB'(128));
        chk("b2b_f2_e24", WB'(el(first_w1, 24)), WB'(52));
        chk("b2b_f2_e0", WB'(el(first_w1, 0)), WB'(0));

        load_rand();
        clear_stats();
        run_frame(1'b1);
        step(1'b0);
        chk("rand_nwin", WB'(nwin), WB'(64));

        load_idx();
        for (int i = 0; i < 70; i++) step(1'b1);
        valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) ew[c] = '0;
        chk("mid_rst_valid", WB'(vob), '0);
        chk("mid_rst_win1", win1, '0);
        chk("mid_rst_win3", win3, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_win2", win2, '0);
        rst_n = 1'b1;
        pos = 0;
        clear_stats();
        run_frame(1'b0);
        step(1'b0);
        check_idx_frame("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
